exc_pipe: RTL

//  Parametrised exception-code pipeline for the 5-stage MIPS core. It carries {valid, exccode, pc, bd} through

---
 rtl/exc_pipe_if.sv | 35 +++
 rtl/exc_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/exc_pipe_if.sv
// Bus between the exception pipeline and its environment.
// The CP0/datapath side is the master; exc_pipe is the slave.
interface exc_pipe_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CODE_W = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 8
);
  logic                       in_vld;
  logic [CODE_W-1:0]          in_code;
  logic [PC_W-1:0]            in_pc;
  logic                       in_bd;
  logic [STAGES*CODE_W-1:0]   src_code;
  logic [STAGES-1:0]          stall;
  logic                       int_req;
  logic                       eret;
  logic [STAGES*CODE_W-1:0]   st_code;
  logic                       exc_req;
  logic [CODE_W-1:0]          exc_code;
  logic [PC_W-1:0]            exc_epc;
  logic                       exc_bd;
  logic                       flush;
  logic [CNT_W-1:0]           exc_cnt;
  logic [CODE_W-1:0]          last_code;

  modport master (
    output in_vld, in_code, in_pc, in_bd, src_code, stall, int_req, eret,
    input  st_code, exc_req, exc_code, exc_epc, exc_bd, flush, exc_cnt, last_code
  );

  modport slave (
    input  in_vld, in_code, in_pc, in_bd, src_code, stall, int_req, eret,
    output st_code, exc_req, exc_code, exc_epc, exc_bd, flush, exc_cnt, last_code
  );
endinterface

// File: rtl/exc_pipe.sv
// Exception-code pipeline: carries the earliest code per instruction down the stages
// and makes the interrupt/exception decision at the last stage.
module exc_pipe #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CODE_W = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  exc_pipe_if.slave  bus
);
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0]              vld;
  logic [STAGES-1:0]              bd;
  logic [STAGES-1:0][CODE_W-1:0]  code;
  logic [STAGES-1:0][PC_W-1:0]    pc;
  logic [STAGES-1:0][CODE_W-1:0]  src;
  logic [STAGES-1:0][CODE_W-1:0]  m;
  logic                           pcv_last;
  logic                           int_take;
  logic                           exc_take;
  logic                           exc_req;
  logic                           flush;
  logic [CODE_W-1:0]              exc_code;
  logic [CNT_W-1:0]               cnt;
  logic [CODE_W-1:0]              last;

  assign src = bus.src_code;

  // Earliest recorded code wins; empty stages report no code.
  always_comb begin
    m = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (vld[k]) m[k] = (code[k] != '0) ? code[k] : src[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              s_vld;
    logic              s_bd;
    logic [CODE_W-1:0] s_code;
    logic [PC_W-1:0]   s_pc;
    logic              up_stall;
    logic              r_vld;
    logic              r_bd;
    logic [CODE_W-1:0] r_code;
    logic [PC_W-1:0]   r_pc;

    if (k == 0) begin : g_src
      assign s_vld    = bus.in_vld;
      assign s_code   = bus.in_code;
      assign s_pc     = bus.in_pc;
      assign s_bd     = bus.in_bd;
      assign up_stall = 1'b0;
    end else begin : g_src
      assign s_vld    = vld[k-1];
      assign s_code   = m[k-1];
      assign s_pc     = pc[k-1];
      assign s_bd     = bd[k-1];
      assign up_stall = bus.stall[k-1];
    end

    // A stalled upstream stage feeds a bubble that still carries its pc/bd.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        r_vld  <= 1'b0;
        r_code <= '0;
        r_pc   <= '0;
        r_bd   <= 1'b0;
      end else if (!bus.stall[k]) begin
        r_vld  <= s_vld & ~up_stall;
        r_code <= up_stall ? '0 : s_code;
        r_pc   <= s_pc;
        r_bd   <= s_bd;
      end
    end

    assign vld[k]  = r_vld;
    assign code[k] = r_code;
    assign pc[k]   = r_pc;
    assign bd[k]   = r_bd;
  end

  // Only the commit stage's pc-valid flag is ever observed.
  always_ff @(posedge clk) begin
    if (reset || flush)      pcv_last <= 1'b0;
    else if (!bus.stall[LAST]) pcv_last <= 1'b1;
  end

  assign int_take = bus.int_req & pcv_last;
  assign exc_take = vld[LAST] & (m[LAST] != '0);
  assign exc_req  = int_take | exc_take;
  assign exc_code = int_take ? '0 : m[LAST];
  assign flush    = exc_req | bus.eret;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      last <= '0;
    end else if (exc_req) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
      last <= exc_code;
    end
  end

  assign bus.st_code   = m;
  assign bus.exc_req   = exc_req;
  assign bus.exc_code  = exc_code;
  assign bus.exc_epc   = pc[LAST] - (bd[LAST] ? PC_W'(4) : PC_W'(0));
  assign bus.exc_bd    = bd[LAST];
  assign bus.flush     = flush;
  assign bus.exc_cnt   = cnt;
  assign bus.last_code = last;
endmodule
